// File: rtl/dma_tile_sequencer.sv
// Per-pass DMA sequencer: filter load, bias load, then per spatial tile the
// ifmap channel loads, one compute window and the opsum channel stores.
module dma_tile_sequencer #(
    parameter int TILE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [1:0]        layer_type_i,
    input  logic [6:0]        tile_D_i,
    input  logic [6:0]        tile_K_i,
    input  logic [TILE_W-1:0] n_tiles_i,
    input  logic              dma_ack_i,
    input  logic              dma_interrupt_i,
    input  logic              compute_done_i,
    output logic [1:0]        input_type_o,
    output logic [1:0]        layer_type_o,
    output logic              dma_req_o,
    output logic [6:0]        chan_cnt_o,
    output logic [TILE_W-1:0] tile_cnt_o,
    output logic              compute_start_o,
    output logic              busy_o,
    output logic              pass_done_o,
    output logic              proto_err_o
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FILT_REQ,
        S_FILT_WAIT,
        S_BIAS_REQ,
        S_BIAS_WAIT,
        S_IFM_REQ,
        S_IFM_WAIT,
        S_COMP_START,
        S_COMP_WAIT,
        S_OPS_REQ,
        S_OPS_WAIT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        layer_q, layer_d;
    logic [6:0]        cfg_d_q, cfg_d_d;
    logic [6:0]        cfg_k_q, cfg_k_d;
    logic [TILE_W-1:0] cfg_n_q, cfg_n_d;
    logic [6:0]        chan_q, chan_d;
    logic [TILE_W-1:0] tile_q, tile_d;
    logic              err_q, err_d;

    state_t            tile_first_state;
    state_t            tile_end_state;
    logic [TILE_W-1:0] tile_end_cnt;
    logic              in_wait;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            layer_q <= '0;
            cfg_d_q <= '0;
            cfg_k_q <= '0;
            cfg_n_q <= '0;
            chan_q  <= '0;
            tile_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            cfg_d_q <= cfg_d_d;
            cfg_k_q <= cfg_k_d;
            cfg_n_q <= cfg_n_d;
            chan_q  <= chan_d;
            tile_q  <= tile_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        cfg_d_d = cfg_d_q;
        cfg_k_d = cfg_k_q;
        cfg_n_d = cfg_n_q;
        chan_d  = chan_q;
        tile_d  = tile_q;
        err_d   = err_q;

        // A tile with no ifmap channels goes straight to its compute window.
        tile_first_state = (cfg_d_q == '0) ? S_COMP_START : S_IFM_REQ;
        if (tile_q == cfg_n_q - TILE_W'(1)) begin
            tile_end_state = S_DONE;
            tile_end_cnt   = tile_q;
        end else begin
            tile_end_state = tile_first_state;
            tile_end_cnt   = tile_q + TILE_W'(1);
        end

        in_wait = (state_q == S_FILT_WAIT) || (state_q == S_BIAS_WAIT) ||
                  (state_q == S_IFM_WAIT)  || (state_q == S_OPS_WAIT);
        if (dma_interrupt_i && !in_wait) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    layer_d = layer_type_i;
                    cfg_d_d = tile_D_i;
                    cfg_k_d = tile_K_i;
                    cfg_n_d = n_tiles_i;
                    chan_d  = '0;
                    tile_d  = '0;
                    err_d   = 1'b0;
                    state_d = S_FILT_REQ;
                end
            end
            S_FILT_REQ: if (dma_ack_i) state_d = S_FILT_WAIT;
            S_FILT_WAIT: if (dma_interrupt_i) state_d = S_BIAS_REQ;
            S_BIAS_REQ: if (dma_ack_i) state_d = S_BIAS_WAIT;
            S_BIAS_WAIT: begin
                if (dma_interrupt_i) begin
                    state_d = (cfg_n_q == '0) ? S_DONE : tile_first_state;
                end
            end
            S_IFM_REQ: if (dma_ack_i) state_d = S_IFM_WAIT;
            S_IFM_WAIT: begin
                if (dma_interrupt_i) begin
                    if (chan_q == cfg_d_q - 7'd1) begin
                        chan_d  = '0;
                        state_d = S_COMP_START;
                    end else begin
                        chan_d  = chan_q + 7'd1;
                        state_d = S_IFM_REQ;
                    end
                end
            end
            S_COMP_START: state_d = S_COMP_WAIT;
            S_COMP_WAIT: begin
                if (compute_done_i) begin
                    if (cfg_k_q == '0) begin
                        state_d = tile_end_state;
                        tile_d  = tile_end_cnt;
                    end else begin
                        state_d = S_OPS_REQ;
                    end
                end
            end
            S_OPS_REQ: if (dma_ack_i) state_d = S_OPS_WAIT;
            S_OPS_WAIT: begin
                if (dma_interrupt_i) begin
                    if (chan_q == cfg_k_q - 7'd1) begin
                        chan_d  = '0;
                        state_d = tile_end_state;
                        tile_d  = tile_end_cnt;
                    end else begin
                        chan_d  = chan_q + 7'd1;
                        state_d = S_OPS_REQ;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        input_type_o    = 2'd0;
        dma_req_o       = 1'b0;
        compute_start_o = 1'b0;
        pass_done_o     = 1'b0;
        case (state_q)
            S_FILT_REQ:   begin input_type_o = 2'd0; dma_req_o = 1'b1; end
            S_FILT_WAIT:  input_type_o = 2'd0;
            S_BIAS_REQ:   begin input_type_o = 2'd2; dma_req_o = 1'b1; end
            S_BIAS_WAIT:  input_type_o = 2'd2;
            S_IFM_REQ:    begin input_type_o = 2'd1; dma_req_o = 1'b1; end
            S_IFM_WAIT:   input_type_o = 2'd1;
            S_COMP_START: begin input_type_o = 2'd1; compute_start_o = 1'b1; end
            S_COMP_WAIT:  input_type_o = 2'd1;
            S_OPS_REQ:    begin input_type_o = 2'd3; dma_req_o = 1'b1; end
            S_OPS_WAIT:   input_type_o = 2'd3;
            S_DONE:       begin input_type_o = 2'd3; pass_done_o = 1'b1; end
            default:      input_type_o = 2'd0;
        endcase
    end

    assign busy_o       = (state_q != S_IDLE);
    assign layer_type_o = layer_q;
    assign chan_cnt_o   = chan_q;
    assign tile_cnt_o   = tile_q;
    assign proto_err_o  = err_q;

endmodule

// File: tb/tb_dma_tile_sequencer.sv
// Bench for dma_tile_sequencer: a responder plays DMA and PE array with random
// delays; observed transfers are compared with the list implied by the pass config.
module tb_dma_tile_sequencer;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic [1:0]    layer_type_i;
    logic [6:0]    tile_D_i;
    logic [6:0]    tile_K_i;
    logic [TW-1:0] n_tiles_i;
    logic          dma_ack_i;
    logic          dma_interrupt_i;
    logic          compute_done_i;
    logic [1:0]    input_type_o;
    logic [1:0]    layer_type_o;
    logic          dma_req_o;
    logic [6:0]    chan_cnt_o;
    logic [TW-1:0] tile_cnt_o;
    logic          compute_start_o;
    logic          busy_o;
    logic          pass_done_o;
    logic          proto_err_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    dma_tile_sequencer #(.TILE_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .layer_type_i(layer_type_i),
        .tile_D_i(tile_D_i), .tile_K_i(tile_K_i), .n_tiles_i(n_tiles_i),
        .dma_ack_i(dma_ack_i), .dma_interrupt_i(dma_interrupt_i),
        .compute_done_i(compute_done_i), .input_type_o(input_type_o),
        .layer_type_o(layer_type_o), .dma_req_o(dma_req_o), .chan_cnt_o(chan_cnt_o),
        .tile_cnt_o(tile_cnt_o), .compute_start_o(compute_start_o), .busy_o(busy_o),
        .pass_done_o(pass_done_o), .proto_err_o(proto_err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
        end
    endtask

    function automatic int key(input int t, input int c, input int tl);
        return (t << 15) | (c << 8) | tl;
    endfunction

    task automatic quiet_inputs();
        start_i = 1'b0; dma_ack_i = 1'b0; dma_interrupt_i = 1'b0; compute_done_i = 1'b0;
    endtask

    // One pass. Optional disturbances: a start pulse during the first ifmap wait,
    // an interrupt during the filter request, a reset during the first tile-1 opsum wait.
    task automatic run_pass(input int d, input int k, input int n, input int lt,
                            input int amin, input int amax, input int imin, input int imax,
                            input bit poke, input bit irq_filt, input bit rst_ops1,
                            input bit fixed_hold);
        int exp_q[$];
        int got_q[$];
        int age = 0, ack_dly = 0, irq_wait = 0, comp_wait = 0, starts = 0, last_evt = -10;
        bit done = 0, aborted = 0, poked = 0, filt_done = 0, stable = 1;
        bit err_chk = 0, drop_chk = 0, after_evt = 0, rst_arm = 0;
        int rt = 0, rc = 0, rtl = 0;

        exp_q.push_back(key(0, 0, 0));
        exp_q.push_back(key(2, 0, 0));
        for (int t = 0; t < n; t++) begin
            for (int c = 0; c < d; c++) exp_q.push_back(key(1, c, t));
            for (int c = 0; c < k; c++) exp_q.push_back(key(3, c, t));
        end

        @(negedge clk);
        layer_type_i = 2'(lt); tile_D_i = 7'(d); tile_K_i = 7'(k); n_tiles_i = TW'(n);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("req_after_start", dma_req_o, 1);
        chk("busy_in_pass", busy_o, 1);
        chk("err_clear_on_start", proto_err_o, 0);

        for (int c = 0; c < 3000; c++) begin
            if (c > 0) @(negedge clk);
            dma_ack_i = 1'b0; dma_interrupt_i = 1'b0; compute_done_i = 1'b0; start_i = 1'b0;

            if (err_chk) begin
                chk("err_set_in_filt_req", proto_err_o, 1);
                chk("filt_req_held", {dma_req_o, input_type_o}, {1'b1, 2'd0});
                err_chk = 0;
            end
            if (drop_chk) begin
                chk("req_drop_after_ack", dma_req_o, 0);
                drop_chk = 0;
            end
            if (after_evt) begin
                chk("next_step_1cyc", dma_req_o | compute_start_o | pass_done_o, 1);
                after_evt = 0;
            end
            if (pass_done_o) begin
                chk("done_gap", cyc - last_evt, 1);
                done = 1;
                break;
            end
            if (rst_arm) begin
                rst_n = 1'b0;
                @(negedge clk);
                chk("rst_outputs_zero",
                    {dma_req_o, compute_start_o, pass_done_o, busy_o, proto_err_o,
                     input_type_o, layer_type_o, chan_cnt_o, tile_cnt_o}, 0);
                rst_n = 1'b1;
                @(negedge clk);
                chk("rst_no_pass_done", {pass_done_o, busy_o}, 0);
                aborted = 1;
                break;
            end

            if (irq_wait > 0) begin
                irq_wait--;
                if (irq_wait == 0) begin
                    dma_interrupt_i = 1'b1; last_evt = cyc; after_evt = 1;
                end
            end
            if (comp_wait > 0) begin
                comp_wait--;
                if (comp_wait == 0) begin
                    compute_done_i = 1'b1; last_evt = cyc; after_evt = 1;
                end
            end
            if (compute_start_o) begin
                starts++;
                comp_wait = $urandom_range(1, 3);
            end

            if (dma_req_o) begin
                if (age == 0) begin
                    rt = int'(input_type_o); rc = int'(chan_cnt_o); rtl = int'(tile_cnt_o);
                    stable = 1;
                    ack_dly = $urandom_range(amin, amax);
                end else if (rt != int'(input_type_o) || rc != int'(chan_cnt_o) ||
                             rtl != int'(tile_cnt_o)) begin
                    stable = 0;
                end
                age++;
                if (irq_filt && !filt_done) begin
                    dma_interrupt_i = 1'b1; filt_done = 1; err_chk = 1;
                end else if (age > ack_dly) begin
                    dma_ack_i = 1'b1;
                    chk("req_fields_stable", stable, 1);
                    if (fixed_hold) chk("req_hold_cycles", age, amin + 1);
                    got_q.push_back(key(rt, rc, rtl));
                    age = 0; drop_chk = 1;
                    irq_wait = $urandom_range(imin, imax);
                    if (rst_ops1 && rt == 3 && rtl == 1) rst_arm = 1;
                end
            end else if (age > 0) begin
                chk("req_held_until_ack", dma_req_o, 1);
                age = 0;
            end

            if (poke && !poked && got_q.size() == 3 && !dma_req_o) begin
                start_i = 1'b1;
                layer_type_i = ~layer_type_i; tile_D_i = 7'd5; tile_K_i = 7'd6; n_tiles_i = TW'(7);
                poked = 1;
            end
        end
        quiet_inputs();

        if (!aborted) begin
            chk("pass_done_seen", done, 1);
            chk("xfer_count", got_q.size(), exp_q.size());
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
                chk($sformatf("xfer_%0d", i), got_q[i], exp_q[i]);
            chk("compute_starts", starts, n);
            @(negedge clk);
            chk("idle_after_done", {busy_o, pass_done_o, dma_req_o, input_type_o}, 0);
            chk("layer_latched", layer_type_o, lt);
            chk("tile_cnt_hold", tile_cnt_o, (n > 0) ? n - 1 : 0);
            chk("chan_cnt_hold", chan_cnt_o, 0);
            chk("err_at_end", proto_err_o, irq_filt);
        end
    endtask

    initial begin
        quiet_inputs();
        layer_type_i = '0; tile_D_i = '0; tile_K_i = '0; n_tiles_i = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {dma_req_o, compute_start_o, pass_done_o, busy_o, proto_err_o,
             input_type_o, layer_type_o, chan_cnt_o, tile_cnt_o}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        dma_ack_i = 1'b1;
        @(negedge clk);
        dma_ack_i = 1'b0;
        chk("ack_in_idle_ignored", {busy_o, dma_req_o}, 0);

        run_pass(2, 3, 2, 0, 0, 0, 2, 2, 0, 0, 0, 1);
        run_pass(1, 1, 1, 1, 5, 5, 1, 3, 0, 0, 0, 1);
        run_pass(3, 2, 0, 0, 0, 2, 1, 3, 0, 0, 0, 0);
        run_pass(0, 1, 1, 1, 0, 2, 1, 3, 0, 0, 0, 0);
        run_pass(0, 0, 2, 0, 0, 2, 1, 3, 0, 0, 0, 0);
        run_pass(2, 2, 2, 0, 0, 2, 1, 3, 1, 0, 0, 0);
        run_pass(1, 1, 1, 0, 0, 1, 1, 2, 0, 1, 0, 0);
        run_pass(1, 2, 3, 1, 0, 1, 1, 2, 0, 0, 1, 0);
        run_pass(2, 1, 2, 0, 0, 2, 1, 3, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            run_pass($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
                     $urandom_range(0, 1), 0, 3, 1, 4, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dma_tile_sequencer.md
# dma_tile_sequencer

Per-pass controller that drives the DMA address generator and the DMA engine. Sequences one filter load, one bias load, then per spatial tile: tile_D ifmap channel loads, one compute window, tile_K opsum channel stores. Selects the transfer class (`input_type_o`), runs the req/ack/interrupt handshake with the DMA, and publishes channel and tile counters for address generation. Sits between the tile scheduler (start/pass_done) and the DMA address generator/DMA engine.

## Interface
- `TILE_W`, default 8: width of the spatial-tile count.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start_i`  in  1  one-cycle pulse; begins a pass. Accepted only in IDLE.
- `layer_type_i`  in  2  0=PW, 1=DW; latched at start, echoed on `layer_type_o`.
- `tile_D_i`  in  7  ifmap channels per tile; latched at start.
- `tile_K_i`  in  7  opsum channels per tile; latched at start.
- `n_tiles_i`  in  TILE_W  spatial tiles per pass; latched at start.
- `dma_ack_i`  in  1  DMA accepts the current request.
- `dma_interrupt_i`  in  1  one-cycle pulse; current transfer complete.
- `compute_done_i`  in  1  one-cycle pulse; PE array finished the current tile.
- `input_type_o`  out  2  0=filter, 1=ifmap, 2=bias, 3=opsum.
- `layer_type_o`  out  2  latched layer type.
- `dma_req_o`  out  1  level request, held until ack.
- `chan_cnt_o`  out  7  channel index within the current ifmap/opsum phase.
- `tile_cnt_o`  out  TILE_W  current spatial tile index.
- `compute_start_o`  out  1  one-cycle pulse; tile inputs resident.
- `busy_o`  out  1  high in every state except IDLE.
- `pass_done_o`  out  1  one-cycle pulse at pass end.
- `proto_err_o`  out  1  sticky; set on an interrupt outside a WAIT state; cleared by reset or accepted start.

## Operation
- States: IDLE, FILT_REQ, FILT_WAIT, BIAS_REQ, BIAS_WAIT, IFM_REQ, IFM_WAIT, COMP_START, COMP_WAIT, OPS_REQ, OPS_WAIT, DONE.
- IDLE + start_i: latch config; clear tile_cnt, chan_cnt, proto_err; go to FILT_REQ. start_i in any other state is ignored.
- *_REQ: `dma_req_o`=1 (Moore). On `dma_ack_i`=1, go to the matching *_WAIT. Ack while not requesting is ignored.
- *_WAIT: `dma_req_o`=0. On `dma_interrupt_i`:
  - FILT_WAIT goes to BIAS_REQ.
  - BIAS_WAIT goes to the tile phase.
  - IFM_WAIT: if chan_cnt==tile_D-1, clear chan_cnt and go to COMP_START; else chan_cnt+1 and back to IFM_REQ.
  - OPS_WAIT: if chan_cnt==tile_K-1, clear chan_cnt and end the tile; else chan_cnt+1 and back to OPS_REQ.
- Tile phase entry: if n_tiles==0 go to DONE. Otherwise go to IFM_REQ, or to COMP_START if tile_D==0.
- COMP_START: pulse `compute_start_o` for one cycle, then COMP_WAIT. On `compute_done_i`, go to OPS_REQ, or end the tile if tile_K==0.
- Tile end: if tile_cnt==n_tiles-1, go to DONE; else tile_cnt+1 and go to IFM_REQ (COMP_START if tile_D==0).
- DONE: `pass_done_o`=1 for one cycle, then IDLE. Counters hold their last values until the next start.
- `input_type_o` by state:
  - FILT_*: 0.
  - IFM_*, COMP_*: 1.
  - BIAS_*: 2.
  - OPS_*, DONE, IDLE: 3 in DONE; IDLE drives 0.
- `input_type_o` and `chan_cnt_o` are stable for the whole REQ+WAIT of a transfer.
- Interrupt in a non-WAIT state: no state change, set `proto_err_o`.
- Simultaneous interrupt and `compute_done_i` in COMP_WAIT: compute_done is taken and the error flag is set.

## Timing
- Reset: state IDLE. `dma_req_o`, `compute_start_o`, `pass_done_o`, `busy_o`, `proto_err_o` = 0. `input_type_o`, `layer_type_o`, `chan_cnt_o`, `tile_cnt_o` = 0.
- Reset mid-pass aborts immediately; the next cycle is IDLE with reset values, and no pass_done is issued.
- Start to first request: `dma_req_o` rises the cycle after start_i.
- Ack sampled the same cycle as req: req drops the next cycle. Zero-wait ack gives a 1-cycle REQ.
- Interrupt to next request: 1 cycle.
- Last opsum interrupt to `pass_done_o`: 1 cycle (DONE), then IDLE on the next cycle.
- Transfers per pass = 2 + n_tiles·(tile_D+tile_K). The counter widths are exact; no wrap occurs because compares use latched values.

## Test plan
- D=2, K=3, n=2, PW, ack immediate, interrupt 2 cycles after ack → input_type sequence 0,2,1,1,3,3,3,1,1,3,3,3; 12 acks; 2 compute_start pulses; one pass_done; chan_cnt 0..1 and 0..2 per phase.
- Ack delayed 5 cycles → dma_req_o held high 6 cycles; input_type and chan_cnt unchanged throughout.
- n=0 → exactly filter and bias transfers, then pass_done 1 cycle after the bias interrupt, with no compute_start. D=0, K=1, n=1 → compute_start right after bias, then one opsum transfer.
- start_i pulsed during IFM_WAIT → ignored; counters and latched config unchanged. Interrupt in FILT_REQ → no advance, proto_err_o=1 until the next accepted start.
- rst_n low during OPS_WAIT at tile 1 → all outputs 0 the next cycle. A fresh start then runs a complete pass from filter load.
